// File: rtl/mac_pkg.sv
// Shared types and sizing helpers for the array/Kogge-Stone MAC pipeline.
package mac_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_DOT_LEN = 4;

    // Bit count needed to index n items, never less than one bit.
    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Product width plus enough headroom for n terms and the carry-ins.
    function automatic int acc_width_default(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } grp_state_t;

endpackage

// File: rtl/ks_adder.sv
// Combinational Kogge-Stone adder: s = x + y + ci, co = carry out of bit W-1.
module ks_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W-1:0] gen;
    logic [W-1:0] prp;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W:0]   c;

    always_comb begin
        gen = x & y;
        prp = x ^ y;
        gn  = '0;
        pn  = '0;
        // Parallel-prefix levels: span doubles each pass until it covers W bits.
        for (int d = 1; d < W; d = d * 2) begin
            gn = gen;
            pn = prp;
            for (int k = d; k < W; k++) begin
                gn[k] = gen[k] | (prp[k] & gen[k-d]);
                pn[k] = prp[k] & prp[k-d];
            end
            gen = gn;
            prp = pn;
        end
        // gen/prp now hold group generate/propagate for bits [k:0]; fold in ci.
        c  = {gen | (prp & {W{ci}}), ci};
        s  = (x ^ y) ^ c[W-1:0];
        co = c[W];
    end

endmodule

// File: rtl/array_ks_mac_pipe.sv
// Pipelined dot-product MAC: capture -> array multiply -> Kogge-Stone accumulate; SATURATE_EN clamps on overflow.
// Latency: result pulse on the 3rd edge counting the edge that samples the group's last pair; 1 pair/cycle.
// No backpressure: every in_valid pair is accepted unless clr is high in the same cycle.
module array_ks_mac_pipe
    import mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DOT_LEN   = DEF_DOT_LEN,
    parameter int ACC_WIDTH = acc_width_default(WIDTH, DOT_LEN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 cout,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = clog2_safe(DOT_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DOT_LEN - 1);

    // Stage 1: operand capture
    logic             v1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             c1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            a1 <= '0;
            b1 <= '0;
            c1 <= 1'b0;
        end else begin
            v1 <= in_valid & ~clr;
            if (in_valid & ~clr) begin
                a1 <= a;
                b1 <= b;
                c1 <= cin;
            end
        end
    end

    // Stage 2: array multiplier, one shifted partial-product row per multiplier bit
    logic [PW-1:0] row [WIDTH+1];

    assign row[0] = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [PW-1:0] pp;
        assign pp         = PW'(a1 & {WIDTH{b1[i]}}) << i;
        assign row[i + 1] = row[i] + pp;
    end

    logic          v2;
    logic [PW-1:0] p2;
    logic          c2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            p2 <= '0;
            c2 <= 1'b0;
        end else begin
            v2 <= v1 & ~clr;
            if (v1 & ~clr) begin
                p2 <= row[WIDTH];
                c2 <= c1;
            end
        end
    end

    // Stage 3: accumulate
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 sticky;

    logic                 first_term;
    logic                 last_term;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] p_ext;
    logic                 sticky_base;
    logic [ACC_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] acc_next;

    always_comb begin
        first_term  = (cnt == '0);
        last_term   = v2 && (cnt == LAST);
        // A new group starts from zero; stale acc/sticky of the previous group are ignored.
        acc_base    = first_term ? '0 : acc;
        sticky_base = first_term ? 1'b0 : sticky;
        p_ext       = '0;
        p_ext[PW-1:0] = p2;
    end

    ks_adder #(
        .W (ACC_WIDTH)
    ) u_acc_add (
        .x  (acc_base),
        .y  (p_ext),
        .ci (c2),
        .s  (sum),
        .co (carry)
    );

    always_comb begin
        ovf = sticky_base | carry;
`ifdef SATURATE_EN
        acc_next = ovf ? '1 : sum;
`else
        acc_next = sum;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            acc    <= '0;
            sticky <= 1'b0;
        end else if (v2) begin
            acc    <= acc_next;
            sticky <= ovf;
            cnt    <= last_term ? '0 : cnt + 1'b1;
            if (last_term) begin
                result <= acc_next;
                cout   <= ovf;
            end
        end
    end

    // Group tracking; DONE lasts exactly one cycle and drives the result pulse.
    grp_state_t state;
    grp_state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (v2) state_nxt = last_term ? DONE : ACCUM;
            ACCUM:   if (last_term) state_nxt = DONE;
            DONE:    state_nxt = v2 ? (last_term ? DONE : ACCUM) : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    assign out_valid = (state == DONE);
    assign busy      = (cnt != '0) | v1 | v2;

endmodule
